// File: rtl/vdp_pkg.sv
// vdp_pkg: shared constants for the VDP CPU port controller.
//   - command codes carried in the second control-port byte
//   - port select values
//   - sequencer state encoding
package vdp_pkg;

    localparam logic [1:0] CODE_VRD  = 2'd0;
    localparam logic [1:0] CODE_VWR  = 2'd1;
    localparam logic [1:0] CODE_REG  = 2'd2;
    localparam logic [1:0] CODE_CRAM = 2'd3;

    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_CTRL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CAPT = 2'd2
    } state_t;

endpackage

// File: rtl/vdp_port_ctrl_if.sv
// vdp_port_ctrl_if: VRAM port A request/grant bus between the CPU port
// controller (master) and the VRAM arbiter (slave).
//   vram_req  : request, held until granted
//   vram_we   : write qualifier, valid with vram_req
//   vram_addr : VRAM address
//   vram_di   : write data
//   vram_gnt  : one-cycle grant from the arbiter
//   vram_do   : read data, valid the cycle after vram_gnt
interface vdp_port_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              vram_req;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_di;
    logic              vram_gnt;
    logic [7:0]        vram_do;

    modport master (
        output vram_req, vram_we, vram_addr, vram_di,
        input  vram_gnt, vram_do
    );

    modport slave (
        input  vram_req, vram_we, vram_addr, vram_di,
        output vram_gnt, vram_do
    );
endinterface

// File: rtl/vdp_cmd_latch.sv
// vdp_cmd_latch: two-byte control-port command latch.
// Holds the VRAM address, the command code and the first_byte flag, and
// decodes the completion of a command pair.
//   clk, rst      : clock, synchronous active-high reset
//   i_ctrl_wr     : accepted control-port write
//   i_clr_first   : clears first_byte (control read or any data access)
//   i_inc         : post-increment address (wraps at the top)
//   i_di          : CPU write byte
//   o_addr/o_code : current address and command code
//   o_cmd_done    : this control write is the second byte of a pair
//   o_rd_setup    : second byte carries the read-setup code
//   o_reg_wr      : second byte carries the register-write code
module vdp_cmd_latch
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ctrl_wr,
    input  logic              i_clr_first,
    input  logic              i_inc,
    input  logic [7:0]        i_di,
    output logic [ADDR_W-1:0] o_addr,
    output logic [1:0]        o_code,
    output logic              o_cmd_done,
    output logic              o_rd_setup,
    output logic              o_reg_wr
);
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_code;
    logic              r_first;

    assign o_addr     = r_addr;
    assign o_code     = r_code;
    assign o_cmd_done = i_ctrl_wr & r_first;
    assign o_rd_setup = o_cmd_done & (i_di[7:6] == CODE_VRD);
    assign o_reg_wr   = o_cmd_done & (i_di[7:6] == CODE_REG);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_code  <= CODE_VRD;
            r_first <= 1'b0;
        end else if (i_ctrl_wr) begin
            if (!r_first) begin
                r_addr[7:0] <= i_di;
                r_first     <= 1'b1;
            end else begin
                r_addr[ADDR_W-1:8] <= i_di[ADDR_W-9:0];
                r_code             <= i_di[7:6];
                r_first            <= 1'b0;
            end
        end else begin
            if (i_clr_first) r_first <= 1'b0;
            if (i_inc)       r_addr  <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/vdp_port_ctrl.sv
// vdp_port_ctrl: CPU-side sequencer for the VDP data/control ports.
// Decodes the two-byte command protocol into register writes, CRAM writes
// and VRAM read/write requests over the request/grant bus.
//   clk, rst           : clock, synchronous active-high reset
//   cpu_wr/cpu_rd      : one-cycle strobes, ignored while cpu_busy
//   cpu_port, cpu_di   : port select (0 data, 1 control), write byte
//   cpu_do, cpu_busy   : registered read byte, transaction outstanding
//   status_in/rd       : status byte in, pulse on control-port read
//   reg_we/idx/data    : register file write
//   cram_we/addr/di    : CRAM write
//   vram               : VRAM request/grant bus (master side)
//
// state | meaning
// IDLE  | accepts CPU strobes
// REQ   | vram_req held, waiting for vram_gnt
// CAPT  | read data on vram_do, loaded into the read-ahead buffer
module vdp_port_ctrl
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int CRAM_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic              cpu_port,
    input  logic [7:0]        cpu_di,
    output logic [7:0]        cpu_do,
    output logic              cpu_busy,
    input  logic [7:0]        status_in,
    output logic              status_rd,
    output logic              reg_we,
    output logic [3:0]        reg_idx,
    output logic [7:0]        reg_data,
    output logic              cram_we,
    output logic [CRAM_W-1:0] cram_addr,
    output logic [7:0]        cram_di,
    vdp_port_ctrl_if.master   vram
);
    state_t            r_state, w_state_nxt;
    logic              w_req, w_busy;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_code;
    logic              w_cmd_done, w_rd_setup, w_reg_wr;
    logic              w_idle, w_wr_acc, w_rd_acc;
    logic              w_ctrl_wr, w_data_wr, w_ctrl_rd, w_data_rd;
    logic              w_cram_wr, w_vram_wr, w_start, w_gnt, w_inc;

    logic [7:0]        r_rbuf, r_cpu_do, r_vram_di, r_reg_data, r_cram_di;
    logic              r_vram_we, r_status_rd, r_reg_we, r_cram_we;
    logic [3:0]        r_reg_idx;
    logic [CRAM_W-1:0] r_cram_addr;

    // Write wins over a simultaneous read.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_wr_acc  = cpu_wr & w_idle;
    assign w_rd_acc  = cpu_rd & ~cpu_wr & w_idle;
    assign w_ctrl_wr = w_wr_acc & (cpu_port == PORT_CTRL);
    assign w_data_wr = w_wr_acc & (cpu_port == PORT_DATA);
    assign w_ctrl_rd = w_rd_acc & (cpu_port == PORT_CTRL);
    assign w_data_rd = w_rd_acc & (cpu_port == PORT_DATA);

    assign w_cram_wr = w_data_wr & (w_code == CODE_CRAM);
    assign w_vram_wr = w_data_wr & (w_code != CODE_CRAM);
    assign w_start   = w_rd_setup | w_vram_wr | w_data_rd;
    assign w_gnt     = (r_state == ST_REQ) & vram.vram_gnt;
    // Address advances on the grant, so an aborted request never bumps it.
    assign w_inc     = w_gnt | w_cram_wr;

    vdp_cmd_latch #(.ADDR_W(ADDR_W)) u_cmd_latch (
        .clk         (clk),
        .rst         (rst),
        .i_ctrl_wr   (w_ctrl_wr),
        .i_clr_first (w_ctrl_rd | w_data_wr | w_data_rd),
        .i_inc       (w_inc),
        .i_di        (cpu_di),
        .o_addr      (w_addr),
        .o_code      (w_code),
        .o_cmd_done  (w_cmd_done),
        .o_rd_setup  (w_rd_setup),
        .o_reg_wr    (w_reg_wr)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_REQ;
            ST_REQ: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
                if (vram.vram_gnt) w_state_nxt = r_vram_we ? ST_IDLE : ST_CAPT;
            end
            ST_CAPT: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rbuf      <= '0;
            r_cpu_do    <= '0;
            r_vram_we   <= 1'b0;
            r_vram_di   <= '0;
            r_status_rd <= 1'b0;
            r_reg_we    <= 1'b0;
            r_reg_idx   <= '0;
            r_reg_data  <= '0;
            r_cram_we   <= 1'b0;
            r_cram_addr <= '0;
            r_cram_di   <= '0;
        end else begin
            r_status_rd <= w_ctrl_rd;
            r_reg_we    <= w_reg_wr;
            r_cram_we   <= w_cram_wr;
            if (w_start) r_vram_we <= w_vram_wr;
            if (w_vram_wr) r_vram_di <= cpu_di;
            if (w_data_wr) r_rbuf <= cpu_di;
            else if (r_state == ST_CAPT) r_rbuf <= vram.vram_do;
            if (w_ctrl_rd) r_cpu_do <= status_in;
            else if (w_data_rd) r_cpu_do <= r_rbuf;
            if (w_reg_wr) begin
                r_reg_idx  <= cpu_di[3:0];
                r_reg_data <= w_addr[7:0];
            end
            if (w_cram_wr) begin
                r_cram_addr <= w_addr[CRAM_W-1:0];
                r_cram_di   <= cpu_di;
            end
        end
    end

    assign cpu_do         = r_cpu_do;
    assign cpu_busy       = w_busy;
    assign status_rd      = r_status_rd;
    assign reg_we         = r_reg_we;
    assign reg_idx        = r_reg_idx;
    assign reg_data       = r_reg_data;
    assign cram_we        = r_cram_we;
    assign cram_addr      = r_cram_addr;
    assign cram_di        = r_cram_di;
    assign vram.vram_req  = w_req;
    assign vram.vram_we   = r_vram_we;
    assign vram.vram_addr = w_addr;
    assign vram.vram_di   = r_vram_di;
endmodule

// File: tb/tb_vdp_port_ctrl.sv
// tb_vdp_port_ctrl: directed bench for vdp_port_ctrl with a VRAM arbiter
// model of programmable grant delay.
module tb_vdp_port_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_port = 1'b0;
    logic [7:0] cpu_di = 8'h00, status_in = 8'h00;
    logic [7:0] cpu_do, reg_data, cram_di;
    logic       cpu_busy, status_rd, reg_we, cram_we;
    logic [3:0] reg_idx;
    logic [4:0] cram_addr;

    vdp_port_ctrl_if #(.ADDR_W(14)) vif ();

    vdp_port_ctrl #(.ADDR_W(14), .CRAM_W(5)) dut (
        .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_port(cpu_port), .cpu_di(cpu_di), .cpu_do(cpu_do),
        .cpu_busy(cpu_busy), .status_in(status_in), .status_rd(status_rd),
        .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
        .cram_we(cram_we), .cram_addr(cram_addr), .cram_di(cram_di),
        .vram(vif)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0;
    int gnt_dly = 0;

    // Arbiter model state (written only by the arbiter process)
    logic [7:0]  mem [0:16383];
    int          wait_cnt, wr_cnt = 0, rd_cnt = 0, stab_err = 0;
    logic [13:0] last_wr_addr = '0, last_rd_addr = '0, req_addr0 = '0;
    logic [7:0]  last_wr_data = '0;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h1234] = 8'h5A;
        mem[14'h1235] = 8'h6B;
        vif.vram_gnt = 1'b0;
        vif.vram_do  = 8'h00;
        wait_cnt     = 0;
        forever begin
            @(negedge clk);
            vif.vram_gnt = 1'b0;
            if (vif.vram_req) begin
                if (wait_cnt == 0) req_addr0 = vif.vram_addr;
                if (wait_cnt >= gnt_dly) begin
                    if (vif.vram_addr !== req_addr0) stab_err++;
                    vif.vram_gnt = 1'b1;
                    if (vif.vram_we) begin
                        mem[vif.vram_addr] = vif.vram_di;
                        last_wr_addr = vif.vram_addr;
                        last_wr_data = vif.vram_di;
                        wr_cnt++;
                    end else begin
                        vif.vram_do  = mem[vif.vram_addr];
                        last_rd_addr = vif.vram_addr;
                        rd_cnt++;
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Pulse monitor (written only here)
    int         reg_cnt = 0, cram_cnt = 0, status_cnt = 0, req_cyc = 0, busy_cyc = 0;
    logic [3:0] reg_idx_l = '0;
    logic [7:0] reg_data_l = '0;
    logic [4:0] cram_a_log [0:7];
    logic [7:0] cram_d_log [0:7];

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we) begin
                reg_cnt++;
                reg_idx_l  = reg_idx;
                reg_data_l = reg_data;
            end
            if (cram_we) begin
                if (cram_cnt < 8) begin
                    cram_a_log[cram_cnt] = cram_addr;
                    cram_d_log[cram_cnt] = cram_di;
                end
                cram_cnt++;
            end
            if (status_rd)    status_cnt++;
            if (vif.vram_req) req_cyc++;
            if (cpu_busy)     busy_cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic wr, input logic rd, input logic p, input logic [7:0] d);
        @(negedge clk);
        cpu_wr = wr; cpu_rd = rd; cpu_port = p; cpu_di = d;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic ctrl_wr(input logic [7:0] d); strobe(1'b1, 1'b0, 1'b1, d); endtask
    task automatic data_wr(input logic [7:0] d); strobe(1'b1, 1'b0, 1'b0, d); endtask
    task automatic ctrl_rd(); strobe(1'b0, 1'b1, 1'b1, 8'h00); endtask
    task automatic data_rd(); strobe(1'b0, 1'b1, 1'b0, 8'h00); endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (cpu_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 100), 1'b1);
        @(negedge clk);
    endtask

    function automatic logic [63:0] out_vec();
        return {3'b0, cpu_do, cpu_busy, status_rd, reg_we, reg_idx, reg_data,
                cram_we, cram_addr, cram_di, vif.vram_req, vif.vram_we,
                vif.vram_addr, vif.vram_di};
    endfunction

    int b_reg, b_req, b_busy, b_wr, b_rd, b_cram, b_stat;

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_outputs", out_vec(), 64'h0);

        // Register write: 0x26, 0x80 -> reg 0 = 0x26
        b_reg = reg_cnt; b_req = req_cyc;
        ctrl_wr(8'h26);
        ctrl_wr(8'h80);
        repeat (2) @(negedge clk);
        check("reg_we_count", reg_cnt - b_reg, 1);
        check("reg_idx", reg_idx_l, 4'h0);
        check("reg_data", reg_data_l, 8'h26);
        check("reg_no_vram_req", req_cyc - b_req, 0);

        // VRAM write burst, grant 3 cycles after each request
        gnt_dly = 3;
        ctrl_wr(8'h00);
        ctrl_wr(8'h40);
        b_busy = busy_cyc; b_wr = wr_cnt;
        data_wr(8'hAA);
        wait_idle("burst_wr1_done");
        data_wr(8'hBB);
        wait_idle("burst_wr2_done");
        check("burst_mem0", mem[14'h0000], 8'hAA);
        check("burst_mem1", mem[14'h0001], 8'hBB);
        check("burst_wr_count", wr_cnt - b_wr, 2);
        check("burst_busy_cycles", busy_cyc - b_busy, 8);
        data_wr(8'hCC);
        wait_idle("burst_wr3_done");
        check("burst_final_addr", last_wr_addr, 14'h0002);

        // Read-ahead
        gnt_dly = 0;
        b_rd = rd_cnt;
        ctrl_wr(8'h34);
        ctrl_wr(8'h12);
        wait_idle("prefetch_done");
        check("prefetch_addr", last_rd_addr, 14'h1234);
        check("prefetch_count", rd_cnt - b_rd, 1);
        data_rd();
        check("read1_data", cpu_do, 8'h5A);
        wait_idle("refill1_done");
        check("refill1_addr", last_rd_addr, 14'h1235);
        data_rd();
        check("read2_data", cpu_do, 8'h6B);
        wait_idle("refill2_done");

        // CRAM writes with 5-bit index wrap
        b_cram = cram_cnt; b_req = req_cyc;
        ctrl_wr(8'h1F);
        ctrl_wr(8'hC0);
        data_wr(8'h3F);
        data_wr(8'h0C);
        repeat (2) @(negedge clk);
        check("cram_count", cram_cnt - b_cram, 2);
        check("cram_addr0", cram_a_log[b_cram], 5'h1F);
        check("cram_di0", cram_d_log[b_cram], 8'h3F);
        check("cram_addr1", cram_a_log[b_cram+1], 5'h00);
        check("cram_di1", cram_d_log[b_cram+1], 8'h0C);
        check("cram_no_vram_req", req_cyc - b_req, 0);

        // VRAM address wrap 0x3FFF -> 0x0000
        ctrl_wr(8'hFF);
        ctrl_wr(8'h7F);
        data_wr(8'h11);
        wait_idle("wrap_wr1_done");
        check("wrap_top_addr", last_wr_addr, 14'h3FFF);
        check("wrap_top_data", mem[14'h3FFF], 8'h11);
        data_wr(8'h22);
        wait_idle("wrap_wr2_done");
        check("wrap_zero_addr", last_wr_addr, 14'h0000);
        check("wrap_zero_data", mem[14'h0000], 8'h22);

        // Status read clears first_byte
        status_in = 8'h80;
        b_stat = status_cnt;
        ctrl_wr(8'h10);
        ctrl_rd();
        check("status_data", cpu_do, 8'h80);
        repeat (2) @(negedge clk);
        check("status_rd_count", status_cnt - b_stat, 1);
        ctrl_wr(8'h20);
        ctrl_wr(8'h40);
        data_wr(8'h55);
        wait_idle("first_byte_wr_done");
        check("first_byte_addr", last_wr_addr, 14'h0020);

        // Simultaneous wr+rd: write wins, no status read
        b_stat = status_cnt;
        strobe(1'b1, 1'b1, 1'b1, 8'h33);
        repeat (2) @(negedge clk);
        check("wr_wins_no_status", status_cnt - b_stat, 0);
        ctrl_rd();

        // Strobes while busy are ignored
        gnt_dly = 10;
        ctrl_wr(8'h00);
        ctrl_wr(8'h40);
        b_rd = rd_cnt; b_wr = wr_cnt;
        data_wr(8'h77);
        check("busy_in_req", cpu_busy, 1'b1);
        ctrl_wr(8'h99);
        data_rd();
        wait_idle("busy_wr_done");
        check("busy_wr_addr", last_wr_addr, 14'h0000);
        check("busy_wr_data", last_wr_data, 8'h77);
        check("busy_no_read", rd_cnt - b_rd, 0);
        data_wr(8'h88);
        wait_idle("busy_next_done");
        check("busy_next_addr", last_wr_addr, 14'h0001);
        check("busy_wr_count", wr_cnt - b_wr, 2);

        // Reset during REQ aborts the request
        gnt_dly = 20;
        ctrl_wr(8'h00);
        ctrl_wr(8'h41);
        data_wr(8'h12);
        repeat (2) @(negedge clk);
        check("pre_reset_req", vif.vram_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_dropped", vif.vram_req, 1'b0);
        check("rst_outputs", out_vec(), 64'h0);
        rst = 1'b0;
        gnt_dly = 0;
        b_wr = wr_cnt;
        @(negedge clk);
        data_wr(8'h34);
        wait_idle("post_reset_wr_done");
        check("post_reset_addr", last_wr_addr, 14'h0000);
        check("post_reset_data", mem[14'h0000], 8'h34);
        check("aborted_not_written", mem[14'h0100], 8'h00);
        check("post_reset_wr_count", wr_cnt - b_wr, 1);

        check("handshake_stable", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
